// File: rtl/mem_access_unit.sv
// =============================================================================
// mem_access_unit -- MEM-stage load/store initiator for a word-only MMU port.
// Revision: 1.0
// =============================================================================
`default_nettype none

module mem_access_unit (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STORE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    logic [2:0]  r_state;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_misaligned;
    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [31:0] w_load_ext;
    logic [31:0] w_lane_mask;
    logic [31:0] w_lane_data;
    logic [31:0] w_merged;

    assign req_ready = !rst && (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;

    assign w_misaligned = (req_size == 2'b11)
                       || ((req_size == c_SIZE_HALF) && req_addr[0])
                       || ((req_size == c_SIZE_WORD) && (req_addr[1:0] != 2'b00));

    // Aligned accesses guarantee the lane starts at 8*addr[1:0], so one
    // shift serves byte, half and word (word always has shift 0).
    assign w_shamt   = {r_addr[1:0], 3'b000};
    assign w_shifted = mem_rdata >> w_shamt;

    always_comb begin
        w_load_ext = w_shifted;
        case (r_size)
            c_SIZE_BYTE: w_load_ext = {{24{!r_unsigned && w_shifted[7]}},  w_shifted[7:0]};
            c_SIZE_HALF: w_load_ext = {{16{!r_unsigned && w_shifted[15]}}, w_shifted[15:0]};
            default:     w_load_ext = w_shifted;
        endcase
    end

    always_comb begin
        w_lane_mask = 32'h0000_00FF << w_shamt;
        w_lane_data = {24'd0, r_wdata[7:0]} << w_shamt;
        if (r_size == c_SIZE_HALF) begin
            w_lane_mask = 32'h0000_FFFF << w_shamt;
            w_lane_data = {16'd0, r_wdata[15:0]} << w_shamt;
        end
    end

    assign w_merged = (mem_rdata & ~w_lane_mask) | w_lane_data;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_merge    <= 32'd0;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_err      <= w_misaligned;
                        if (w_misaligned) begin
                            r_rdata <= 32'd0;
                            r_state <= S_RESP;
                        end else if (!req_we) begin
                            r_state <= S_LOAD;
                        end else if (req_size == c_SIZE_WORD) begin
                            r_state <= S_STORE;
                        end else begin
                            r_state <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    if (!mem_stall) begin
                        r_rdata <= w_load_ext;
                        r_state <= S_RESP;
                    end
                end
                S_STORE: begin
                    if (!mem_stall) begin
                        r_rdata <= 32'd0;
                        r_state <= S_RESP;
                    end
                end
                S_RMW_RD: begin
                    if (!mem_stall) begin
                        r_merge <= w_merged;
                        r_state <= S_RMW_WR;
                    end
                end
                S_RMW_WR: begin
                    if (!mem_stall) begin
                        r_rdata <= 32'd0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The MMU gates its address path on mem_read, so writes keep it asserted.
    assign mem_read  = (r_state == S_LOAD) || (r_state == S_STORE)
                    || (r_state == S_RMW_RD) || (r_state == S_RMW_WR);
    assign mem_write = (r_state == S_STORE) || (r_state == S_RMW_WR);
    assign mem_addr  = mem_read ? {r_addr[31:2], 2'b00} : 32'd0;

    always_comb begin
        mem_wd = 32'd0;
        if (r_state == S_STORE) begin
            mem_wd = r_wdata;
        end else if (r_state == S_RMW_WR) begin
            mem_wd = r_merge;
        end
    end

    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// =============================================================================
// tb_mem_access_unit -- directed self-checking bench with a word-memory model.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        sys_clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rdata;
    logic        mem_stall;

    logic        preload;
    logic [31:0] mem [0:15];
    logic        mem_seen;
    logic        mem_seen_clr;

    int checks;
    int errors;

    mem_access_unit dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Word memory standing in for the MMU: combinational read, write on edge.
    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge sys_clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
            mem[0] <= 32'h8899_AABB;
        end else if (mem_write && !mem_stall) begin
            mem[mem_addr[5:2]] <= mem_wd;
        end
    end

    always @(posedge sys_clk) begin
        if (mem_seen_clr) mem_seen <= 1'b0;
        else if (mem_read || mem_write) mem_seen <= 1'b1;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Presents a request in the current cycle; returns #1 into cycle 1.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        step();
        req_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        preload = 1'b1;
        step();
        step();
        preload = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        checks++;
        if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {resp_valid, resp_err, mem_read, mem_write});
        end
        checks++;
        if ({mem_addr, mem_wd, resp_rdata} !== 96'd0) begin
            errors++; $display("FAIL reset_data: got %h %h %h expected zeros", mem_addr, mem_wd, resp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
        step();
    endtask

    task automatic test_loads();
        logic [1:0]  sz   [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
        logic        un   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad   [4] = '{32'h101, 32'h101, 32'h102, 32'h100};
        logic [31:0] expv [4] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h8899_AABB};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, sz[i], un[i], ad[i], 32'hFFFF_FFFF);
            checks++;
            if ({mem_read, mem_write, resp_valid} !== 3'b100 || mem_addr !== 32'h100) begin
                errors++;
                $display("FAIL load%0d_access: got rd=%b wr=%b rv=%b addr=%h expected 1 0 0 00000100",
                         i, mem_read, mem_write, resp_valid, mem_addr);
            end
            step();
            checks++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== expv[i]) begin
                errors++;
                $display("FAIL load%0d_resp: got rv=%b err=%b data=%h expected 1 0 %h",
                         i, resp_valid, resp_err, resp_rdata, expv[i]);
            end
            step();
        end
    endtask

    task automatic test_subword_store();
        issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h1234_5677);
        checks++;
        if ({mem_read, mem_write} !== 2'b10) begin
            errors++; $display("FAIL sb_cycle1: got rd=%b wr=%b expected 1 0", mem_read, mem_write);
        end
        step();
        checks++;
        if ({mem_read, mem_write, resp_valid} !== 3'b110 || mem_wd !== 32'h7799_AABB || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL sb_cycle2: got rd=%b wr=%b rv=%b wd=%h addr=%h expected 1 1 0 7799aabb 00000100",
                     mem_read, mem_write, resp_valid, mem_wd, mem_addr);
        end
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'd0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL sb_cycle3: got rv=%b err=%b data=%h wr=%b expected 1 0 00000000 0",
                     resp_valid, resp_err, resp_rdata, mem_write);
        end
        step();
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h7799_AABB) begin
            errors++; $display("FAIL sb_readback: got rv=%b data=%h expected 1 7799aabb", resp_valid, resp_rdata);
        end
        step();
    endtask

    task automatic test_misaligned();
        logic        we [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ad [3] = '{32'h102, 32'h101, 32'h100};
        for (int i = 0; i < 3; i++) begin
            mem_seen_clr = 1'b1;
            step();
            mem_seen_clr = 1'b0;
            issue(we[i], sz[i], 1'b0, ad[i], 32'hCAFE_F00D);
            checks++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
                errors++;
                $display("FAIL err%0d_resp: got rv=%b err=%b data=%h expected 1 1 00000000",
                         i, resp_valid, resp_err, resp_rdata);
            end
            step();
            step();
            checks++;
            if (mem_seen !== 1'b0) begin errors++; $display("FAIL err%0d_no_access: got %b expected 0", i, mem_seen); end
        end
        checks++;
        if (mem[0] !== 32'h7799_AABB) begin errors++; $display("FAIL err_mem_intact: got %h expected 7799aabb", mem[0]); end
    endtask

    task automatic test_stall();
        mem_stall = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) mem_stall = 1'b0;
            checks++;
            if (mem_read !== 1'b1 || mem_addr !== 32'h100 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: got rd=%b addr=%h rv=%b expected 1 00000100 0",
                         c, mem_read, mem_addr, resp_valid);
            end
            step();
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h7799_AABB) begin
            errors++; $display("FAIL stall_resp: got rv=%b data=%h expected 1 7799aabb", resp_valid, resp_rdata);
        end
        step();
        // Word store stalled for one cycle: write stays asserted with stable data.
        mem_stall = 1'b1;
        issue(1'b1, 2'b10, 1'b0, 32'h104, 32'h5555_AAAA);
        for (int c = 1; c <= 2; c++) begin
            if (c == 2) mem_stall = 1'b0;
            checks++;
            if ({mem_read, mem_write} !== 2'b11 || mem_wd !== 32'h5555_AAAA || mem_addr !== 32'h104) begin
                errors++;
                $display("FAIL sw_stall_cycle%0d: got rd=%b wr=%b wd=%h addr=%h expected 1 1 5555aaaa 00000104",
                         c, mem_read, mem_write, mem_wd, mem_addr);
            end
            step();
        end
        checks++;
        if (resp_valid !== 1'b1 || mem[1] !== 32'h5555_AAAA) begin
            errors++; $display("FAIL sw_stall_commit: got rv=%b mem=%h expected 1 5555aaaa", resp_valid, mem[1]);
        end
        step();
    endtask

    task automatic test_reset_mid_rmw();
        issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_DEAD);
        checks++;
        if ({mem_read, mem_write} !== 2'b10) begin
            errors++; $display("FAIL rmw_rst_cycle1: got rd=%b wr=%b expected 1 0", mem_read, mem_write);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({mem_read, mem_write, resp_valid, req_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL rmw_rst_cycle2: got rd=%b wr=%b rv=%b rdy=%b expected 0 0 0 0",
                     mem_read, mem_write, resp_valid, req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rmw_rst_ready: got %b expected 1", req_ready); end
        step();
        step();
        checks++;
        if (mem[0] !== 32'h7799_AABB || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rmw_rst_mem: got mem=%h rv=%b expected 7799aabb 0", mem[0], resp_valid);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        preload      = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        mem_stall    = 1'b0;
        mem_seen_clr = 1'b1;
        #1;
        test_reset();
        test_loads();
        test_subword_store();
        test_misaligned();
        test_stall();
        test_reset_mid_rmw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
